// File: rtl/divider_arbiter_if.sv
// Request/response bundle between the requesters and divider_arbiter.
//
// Request side: req_valid/req_ready per requester, with operands packed
// requester-major (requester k at [k*DATA_WIDTH +: DATA_WIDTH]) and a
// per-requester sign mode.
// Response side: a single resp_valid/resp_ready channel carrying the
// requester ID, quotient, remainder and watchdog error flag.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the source keeps valid and its
// payload stable until that edge, and ready never depends on a transfer
// that has not happened yet.
//
// modport master: requester/consumer side (drives requests, takes responses)
// modport slave : arbiter side (accepts requests, drives responses)
interface divider_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_in1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_in2;
    logic [NUM_REQ-1:0]            req_sign;

    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    logic [DATA_WIDTH-1:0]         resp_quot;
    logic [DATA_WIDTH-1:0]         resp_rem;
    logic                          resp_err;

    modport master (
        output req_valid, req_in1, req_in2, req_sign, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_err
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_sign, resp_ready,
        output req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_err
    );
endinterface

// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one external radix-2 divider among NUM_REQ
// requesters. A round-robin pick in IDLE latches one operation, START
// pulses div_start for one cycle, WAIT looks for a rising edge of div_done
// (bounded by a TIMEOUT-cycle watchdog), and RESP presents the result until
// the consumer takes it.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   bus (slave)     - request and response channels, see divider_arbiter_if
//   div_start       - one-cycle start pulse to the divider
//   div_in1/in2     - operands, held from START until WAIT is left
//   div_sign        - signed (1) / unsigned (0) mode to the divider
//   div_quot/rem    - divider results
//   div_done        - divider done level
//   dbg_state       - current FSM state (0 IDLE, 1 START, 2 WAIT, 3 RESP)
module divider_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    divider_arbiter_if.slave      bus,
    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_in1,
    output logic [DATA_WIDTH-1:0] div_in2,
    output logic                  div_sign,
    input  logic [DATA_WIDTH-1:0] div_quot,
    input  logic [DATA_WIDTH-1:0] div_rem,
    input  logic                  div_done,
    output logic [1:0]            dbg_state
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  div_done_q;
    logic                  div_start_q, div_start_d;
    logic [DATA_WIDTH-1:0] div_in1_q, div_in1_d;
    logic [DATA_WIDTH-1:0] div_in2_q, div_in2_d;
    logic                  div_sign_q, div_sign_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]       resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] resp_quot_q, resp_quot_d;
    logic [DATA_WIDTH-1:0] resp_rem_q, resp_rem_d;
    logic                  resp_err_q, resp_err_d;
    logic [NUM_REQ-1:0]    req_ready_c;

    // Unpacked views of the operand buses so the grant can index them.
    logic [DATA_WIDTH-1:0] in1_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] in2_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign in1_arr[k] = bus.req_in1[k*DATA_WIDTH +: DATA_WIDTH];
        assign in2_arr[k] = bus.req_in2[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid requester strictly after ptr,
    // wrapping, so the last granted requester has the lowest priority.
    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Only a rising edge counts: a done level left over from the previous
    // operation must not complete the current one.
    logic done_edge;
    assign done_edge = div_done && !div_done_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        div_start_d  = div_start_q;
        div_in1_d    = div_in1_q;
        div_in2_d    = div_in2_q;
        div_sign_d   = div_sign_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_quot_d  = resp_quot_q;
        resp_rem_d   = resp_rem_q;
        resp_err_d   = resp_err_q;
        req_ready_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_c[pick] = 1'b1;
                    gnt_d       = pick;
                    div_in1_d   = in1_arr[pick];
                    div_in2_d   = in2_arr[pick];
                    div_sign_d  = bus.req_sign[pick];
                    div_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                div_start_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Edge is tested first so it wins over a same-cycle timeout.
                if (done_edge) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = gnt_q;
                    resp_quot_d  = div_quot;
                    resp_rem_d   = div_rem;
                    resp_err_d   = 1'b0;
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = gnt_q;
                    resp_quot_d  = '0;
                    resp_rem_d   = '0;
                    resp_err_d   = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    ptr_d        = gnt_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            cnt_q        <= '0;
            div_done_q   <= 1'b0;
            div_start_q  <= 1'b0;
            div_in1_q    <= '0;
            div_in2_q    <= '0;
            div_sign_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_quot_q  <= '0;
            resp_rem_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            div_done_q   <= div_done;
            div_start_q  <= div_start_d;
            div_in1_q    <= div_in1_d;
            div_in2_q    <= div_in2_d;
            div_sign_q   <= div_sign_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_quot_q  <= resp_quot_d;
            resp_rem_q   <= resp_rem_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_quot  = resp_quot_q;
    assign bus.resp_rem   = resp_rem_q;
    assign bus.resp_err   = resp_err_q;
    assign div_start      = div_start_q;
    assign div_in1        = div_in1_q;
    assign div_in2        = div_in2_q;
    assign div_sign       = div_sign_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_divider_arbiter.sv
module tb_divider_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int TO  = 64;
    localparam int LAT = 8;
    localparam int W   = 67;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    logic          div_start;
    logic [DW-1:0] div_in1;
    logic [DW-1:0] div_in2;
    logic          div_sign;
    logic [DW-1:0] div_quot;
    logic [DW-1:0] div_rem;
    logic          div_done;
    logic [1:0]    dbg_state;

    divider_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .div_start (div_start),
        .div_in1   (div_in1),
        .div_in2   (div_in2),
        .div_sign  (div_sign),
        .div_quot  (div_quot),
        .div_rem   (div_rem),
        .div_done  (div_done),
        .dbg_state (dbg_state)
    );

    // ---------------- divider stand-in ----------------
    // Fixed-latency divider; done is a level that stays high until the next
    // start. div_mode 1/2 force done stuck low/high for the watchdog cases.
    logic          div_rst_n;
    int            div_mode;
    logic          m_busy;
    int            m_cnt;
    logic          m_done;
    logic [DW-1:0] m_a, m_b, m_q, m_r;
    logic          m_s;

    assign div_rst_n = ~rst;
    assign div_quot  = m_q;
    assign div_rem   = m_r;
    assign div_done  = (div_mode == 1) ? 1'b0 : (div_mode == 2) ? 1'b1 : m_done;

    always @(posedge clk) begin
        if (!div_rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT - 1;
            m_done <= 1'b0;
            m_a    <= div_in1;
            m_b    <= div_in2;
            m_s    <= div_sign;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (m_s) begin
                    m_q <= DW'($signed(m_a) / $signed(m_b));
                    m_r <= DW'($signed(m_a) % $signed(m_b));
                end else begin
                    m_q <= m_a / m_b;
                    m_r <= m_a % m_b;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int id, input logic [DW-1:0] q,
                                        input logic [DW-1:0] r, input logic e);
        return {2'(id), q, r, e};
    endfunction

    function automatic logic [W-1:0] resp_word();
        return {bus.resp_id, bus.resp_quot, bus.resp_rem, bus.resp_err};
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: requesters that see their ready drop valid afterwards.
    task automatic tick();
        logic [NR-1:0] g;
        g = bus.req_ready;
        if (g != '0) check("grant_onehot", W'($onehot(g)), W'(1));
        if (dbg_state != 2'd0) check("ready_outside_idle", W'(g), W'(0));
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~g;
        #1;
    endtask

    task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic s);
        bus.req_in1[id*DW +: DW] = a;
        bus.req_in2[id*DW +: DW] = b;
        bus.req_sign[id]         = s;
        bus.req_valid[id]        = 1'b1;
        #1;
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        while (!bus.resp_valid && k < 300) begin
            tick();
            k++;
        end
        check("resp_seen", W'(bus.resp_valid), W'(1));
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_zero(input string p);
        check({p, "_req_ready"},  W'(bus.req_ready),  W'(0));
        check({p, "_div_start"},  W'(div_start),      W'(0));
        check({p, "_div_in1"},    W'(div_in1),        W'(0));
        check({p, "_div_in2"},    W'(div_in2),        W'(0));
        check({p, "_div_sign"},   W'(div_sign),       W'(0));
        check({p, "_resp_valid"}, W'(bus.resp_valid), W'(0));
        check({p, "_resp"},       resp_word(),        W'(0));
        check({p, "_state"},      W'(dbg_state),      W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed tests ----------------
    initial begin
        int   k;
        logic seen;
        bus.req_valid  = '0;
        bus.req_in1    = '0;
        bus.req_in2    = '0;
        bus.req_sign   = '0;
        bus.resp_ready = 1'b0;
        div_mode       = 0;

        do_reset();
        chk_zero("reset");

        // Single unsigned op from requester 2: 100 / 7 = 14 r 2.
        issue(2, 32'h0000_0064, 32'h0000_0007, 1'b0);
        check("u_ready", W'(bus.req_ready), W'(4'b0100));
        tick();
        check("u_start", W'(div_start), W'(1));
        check("u_ready_off", W'(bus.req_ready), W'(0));
        tick();
        check("u_start_pulse", W'(div_start), W'(0));
        check("u_div_in1", W'(div_in1), W'(32'h64));
        check("u_div_in2", W'(div_in2), W'(32'h7));
        wait_resp(k);
        // done rises LAT+1 cycles after START, response one cycle later
        check("u_latency", W'(k + 2), W'(11));
        check("u_resp", resp_word(), mk(2, 32'h0000_000E, 32'h0000_0002, 1'b0));
        finish_resp();
        check("u_valid_drop", W'(bus.resp_valid), W'(0));

        // Signed op from requester 0: -100 / 7 = -14 r -2.
        issue(0, 32'hFFFF_FF9C, 32'h0000_0007, 1'b1);
        check("s_ready", W'(bus.req_ready), W'(4'b0001));
        tick();
        tick();
        check("s_wait_sign", W'(div_sign), W'(1));
        check("s_wait_state", W'(dbg_state), W'(2));
        wait_resp(k);
        check("s_resp", resp_word(), mk(0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0));

        // Backpressure with requester 1 waiting: 55 / 4 = 13 r 3.
        issue(1, 32'd55, 32'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", W'(bus.resp_valid), W'(1));
            check("bp_resp", resp_word(), mk(0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0));
            check("bp_no_ready", W'(bus.req_ready), W'(0));
            check("bp_no_start", W'(div_start), W'(0));
        end
        finish_resp();
        check("bp_release_valid", W'(bus.resp_valid), W'(0));
        check("bp_release_grant", W'(bus.req_ready), W'(4'b0010));
        wait_resp(k);
        check("bp_next_resp", resp_word(), mk(1, 32'd13, 32'd3, 1'b0));
        finish_resp();

        // Round-robin: all four valid from reset, then 0 re-requests.
        do_reset();
        issue(0, 32'd1000, 32'd10, 1'b0);
        issue(1, 32'd55, 32'd4, 1'b0);
        issue(2, 32'hFFFF_FFFF, 32'h10, 1'b0);
        issue(3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("rr_first_grant", W'(bus.req_ready), W'(4'b0001));
        exp_q.push_back(mk(0, 32'd100, 32'd0, 1'b0));
        exp_q.push_back(mk(1, 32'd13, 32'd3, 1'b0));
        exp_q.push_back(mk(2, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0));
        exp_q.push_back(mk(3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
        for (int n = 0; n < 5; n++) begin
            wait_resp(k);
            check("rr_resp", resp_word(), exp_q.pop_front());
            if (n == 0) begin
                issue(0, 32'd81, 32'd9, 1'b0);
                exp_q.push_back(mk(0, 32'd9, 32'd0, 1'b0));
            end
            finish_resp();
        end
        check("rr_drain", W'(exp_q.size()), W'(0));

        // Watchdog, done stuck low then stuck high.
        div_mode = 1;
        issue(3, 32'd100, 32'd10, 1'b0);
        check("wd0_ready", W'(bus.req_ready), W'(4'b1000));
        wait_resp(k);
        check("wd0_latency", W'(k), W'(TO + 2));
        check("wd0_resp", resp_word(), mk(3, 32'd0, 32'd0, 1'b1));
        finish_resp();
        div_mode = 2;
        issue(3, 32'd100, 32'd10, 1'b0);
        wait_resp(k);
        check("wd1_latency", W'(k), W'(TO + 2));
        check("wd1_resp", resp_word(), mk(3, 32'd0, 32'd0, 1'b1));
        finish_resp();
        div_mode = 0;

        // Reset while in WAIT discards the operation.
        issue(2, 32'd200, 32'd3, 1'b0);
        tick();
        check("rw_start", W'(div_start), W'(1));
        repeat (5) tick();
        check("rw_in_wait", W'(dbg_state), W'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_zero("rw");
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.resp_valid) seen = 1'b1;
        end
        check("rw_no_resp", W'(seen), W'(0));
        issue(3, 32'd100, 32'd10, 1'b0);
        issue(1, 32'd7, 32'd7, 1'b0);
        check("rw_first_grant", W'(bus.req_ready), W'(4'b0010));
        wait_resp(k);
        check("rw_resp1", resp_word(), mk(1, 32'd1, 32'd0, 1'b0));
        finish_resp();
        wait_resp(k);
        check("rw_resp3", resp_word(), mk(3, 32'd10, 32'd0, 1'b0));
        finish_resp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one radix-2 `divider` instance among several requesters. Round-robin arbitration selects one operation at a time. The block launches it on the divider with a one-cycle start pulse and waits for the divider's done. It then returns the quotient, remainder and requester ID on a single valid/ready response channel. A watchdog returns an error response if the divider never finishes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 32: operand and result width; must match the divider.
- `TIMEOUT`, 64: maximum WAIT cycles before the watchdog aborts; must exceed the divider's worst-case latency.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high. The divider's `rst_n` is driven from `~rst` at top level.
- `req_valid`  in  NUM_REQ: request pending per requester.
- `req_ready`  out  NUM_REQ: one-hot acceptance pulse.
- `req_in1`  in  NUM_REQ*DATA_WIDTH: dividends; requester k is at slice [k*DATA_WIDTH +: DATA_WIDTH].
- `req_in2`  in  NUM_REQ*DATA_WIDTH: divisors, same packing as `req_in1`.
- `req_sign`  in  NUM_REQ: 1 = signed, 0 = unsigned.
- `div_start`  out  1: start pulse to the divider.
- `div_in1`, `div_in2`  out  DATA_WIDTH: operands to the divider, held stable from START until leaving WAIT.
- `div_sign`  out  1: sign mode to the divider.
- `div_quot`, `div_rem`  in  DATA_WIDTH: divider results (`div_out_reg`, `rem_out_reg`).
- `div_done`  in  1: divider done (`done_reg`).
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_id`  out  clog2(NUM_REQ): requester index of the response.
- `resp_quot`, `resp_rem`  out  DATA_WIDTH: captured results.
- `resp_err`  out  1: watchdog timeout; results are forced to 0.

## Operation
- **States:** IDLE, START, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick grant g by round-robin: search upward from `ptr+1` modulo NUM_REQ.
  - `req_ready[g]`=1 combinationally in that cycle only.
  - Latch g and the slices of `req_in1`, `req_in2` and `req_sign` for g at the clock edge, then go to START.
- **START:** `div_start`=1 for exactly one cycle. Clear the watchdog counter and go to WAIT.
- **WAIT:**
  - A `div_done` rising edge (`div_done`=1 with the registered `div_done_q`=0) ends the operation. Capture `div_quot` and `div_rem`, set `resp_err`=0, go to RESP.
  - A level-high `div_done` carried over from a previous operation is not completion.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT with no edge, set `resp_quot`=`resp_rem`=0 and `resp_err`=1, then go to RESP.
  - If the edge and the timeout occur in the same cycle, the edge wins (`resp_err`=0).
- **RESP:**
  - `resp_valid`=1, and all `resp_*` outputs are held stable until `resp_ready`=1.
  - On the handshake cycle, set `ptr` to g and go to IDLE.
  - New requests are not accepted in RESP; `req_ready` is all-zero.
- **Requester rules:**
  - A requester keeps `req_valid` and its operands stable until it sees its `req_ready`.
  - Deasserting `req_valid` before acceptance is legal; that requester is simply skipped.
- **Arbitration:** no requester waits more than NUM_REQ-1 other operations while continuously requesting.

## Timing
- **Reset:**
  - State goes to IDLE and `ptr` to NUM_REQ-1, so requester 0 has first priority.
  - The counter, `div_done_q` and all outputs go to 0: `req_ready`, `div_start`, `div_in1`, `div_in2`, `div_sign`, `resp_valid`, `resp_id`, `resp_quot`, `resp_rem` and `resp_err`.
- **Reset mid-operation:** in any state, reset returns to IDLE on the next edge. The in-flight result is discarded and no response is issued.
- **Latency:**
  - Accept at cycle T, `div_start` at T+1, WAIT from T+2.
  - A done edge seen in cycle D gives `resp_valid` from D+1.
  - A timeout with no done gives `resp_valid` at T+2+TIMEOUT.
- **Throughput:** after the response handshake at cycle R, IDLE at R+1 can accept immediately. The minimum gap between `div_start` pulses is 4 cycles plus the divider latency.
- `req_ready` is never high outside IDLE and never has more than one bit set.

## Test plan
- **Single unsigned op:** requester 2 issues u 0x00000064 / 0x00000007 -> `req_ready`=0b0100 for 1 cycle, then `div_start` pulse, then `resp_id`=2, `resp_quot`=0x0000000E, `resp_rem`=0x00000002, `resp_err`=0.
- **Signed op:** requester 0 issues s 0xFFFFFF9C (-100) / 0x00000007 -> `resp_quot`=0xFFFFFFF2, `resp_rem`=0xFFFFFFFE, `div_sign`=1 during WAIT.
- **Round-robin:** all 4 requesters valid from reset with distinct operands -> grant order 0,1,2,3, then 0 again if 0 re-requests. Each response carries its own ID and correct results, and `req_ready` is one-hot.
- **Backpressure:** hold `resp_ready`=0 for 10 cycles -> `resp_*` outputs stable, `resp_valid` held, no `req_ready` and no `div_start`. Release -> IDLE next cycle.
- **Watchdog:** stub divider with `div_done` stuck at 0, TIMEOUT=64 -> `resp_valid` at accept+66 with `resp_err`=1 and zero results. A stuck-high `div_done` gives the same outcome.
- **Reset in WAIT:** assert `rst` for 1 cycle, 5 cycles after `div_start` -> all outputs 0 and no response. A following request from requester 1 is accepted as the first grant after reset.
